ram_arb_ctrl: RTL and testbench
===============================

Name: ram_arb_ctrl

Overview:
- Two-requester controller for the single-port synchronous RAM (WIDTH x 2**DEPTH, active-high write enable, registered read data).
- Arbitrates round-robin between requester A and requester B, one RAM access per cycle, using valid/ready handshakes.
- Returns read data one cycle after acceptance.
- Provides a hardware clear sequencer that zero-fills the whole array on command.
- Sits between the two bus masters and the RAM instance.

Parameters:
- WIDTH, 32, data word width; must match the RAM.
- DEPTH, 8, address width; the RAM holds 2**DEPTH words.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- a_valid  in  1  requester A has a request
- a_ready  out  1  A request accepted this cycle when a_valid&a_ready
- a_we  in  1  1=write, 0=read
- a_addr  in  DEPTH  A address
- a_wdata  in  WIDTH  A write data
- a_rvalid  out  1  A read data valid (1-cycle pulse)
- a_rdata  out  WIDTH  A read data
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as A, for requester B
- clr_start  in  1  pulse: start clearing the whole RAM
- clr_busy  out  1  clear in progress
- clr_done  out  1  1-cycle pulse on the cycle the final address is written
- ram_addr  out  DEPTH  to RAM Addr
- ram_we  out  1  to RAM We
- ram_din  out  WIDTH  to RAM Datain
- ram_dout  in  WIDTH  from RAM Dataout

Behaviour:
- Reset: synchronous, active-low. When rst_n=0 at a clk edge:
  - state=IDLE, rr_last=B (so A wins first), clear counter=0.
  - All outputs 0: a_rvalid, b_rvalid, clr_busy, clr_done, ram_we, ram_addr, ram_din.
  - a_ready, b_ready held 0 while rst_n=0.
- FSM states: IDLE, CLEAR.
  - IDLE->CLEAR on clr_start=1.
  - CLEAR->IDLE on the cycle the counter equals 2**DEPTH-1.
  - clr_start in CLEAR is ignored.
- IDLE arbitration (combinational grant):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to rr_last.
  - rr_last updates to the granted requester on acceptance only.
  - ready is asserted only for the granted requester; the other sees ready=0.
  - ready does not depend on the requester's own valid beyond grant selection, and never asserts to a requester with valid=0.
- RAM drive in IDLE: ram_addr/ram_we/ram_din come combinationally from the granted request. With no grant: ram_we=0, ram_addr=0.
- Reads:
  - Read accepted in cycle N -> x_rvalid=1 in cycle N+1, with x_rdata = ram_dout in that cycle.
  - x_rvalid is registered from the accept; x_rdata is a combinational pass of ram_dout.
  - x_rdata is don't-care when x_rvalid=0.
- Writes: complete at acceptance; no response pulse.
- Throughput: one accepted request per cycle total. Back-to-back reads alternate A/B under contention.
- CLEAR:
  - a_ready=b_ready=0, clr_busy=1.
  - Each cycle: ram_we=1, ram_din=0, ram_addr=counter; counter increments.
  - clr_start edge at cycle N: addresses 0..2**DEPTH-1 are written in cycles N+1..N+2**DEPTH.
  - clr_done=1 in the last of those cycles; clr_busy=0 from the next cycle.
- clr_start in the same cycle as a valid request in IDLE:
  - The request is still accepted in that cycle.
  - CLEAR begins the following cycle.
- Read accepted in the cycle before CLEAR entry: its rvalid is still delivered. The RAM output register holds through write cycles, so data is intact.
- Address wrap: the clear counter is DEPTH+1 bits internally (or compare before wrap) to avoid a premature terminal match.
- Reset mid-CLEAR: clear aborts, no clr_done, state=IDLE. RAM contents are then partially cleared; this is accepted.
- Same-address read after write: the read is accepted a later cycle and returns the new data. No bypass is needed.

Decomposition:
- ram_ctrl_pkg holds:
  - typedef enum logic {IDLE, CLEAR} ram_ctrl_state_t
  - typedef enum logic {GNT_A, GNT_B} gnt_t
  - localparam defaults WIDTH=32, DEPTH=8
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: clk, rst_n, req[1:0], accept, enable.
  - Outputs: gnt[1:0] one-hot.
  - Holds rr_last internally.

Test Plan:
- Reset: hold rst_n=0 3 cycles with a_valid=1 -> a_ready=0, all outputs 0. First cycle after release: a_ready=1.
- Single requester: A writes 0xDEADBEEF to addr 0x05, then reads 0x05 -> a_rvalid=1 exactly 1 cycle after the read accept, a_rdata=0xDEADBEEF, b_rvalid=0 throughout.
- Contention: A and B both issue continuous reads of addr 0x10 / 0x20, pre-loaded 0x11111111 / 0x22222222 -> grants alternate A,B,A,B. Each rvalid returns its own data one cycle after its accept.
- Clear: preload addr 0x00 and 0xFF with 0xFFFFFFFF, pulse clr_start -> clr_busy high 256 cycles, clr_done pulse on the 256th. Subsequent reads of 0x00 and 0xFF return 0.
- Clear overlap: read of addr 0x07 accepted in the same cycle as clr_start -> rvalid with the correct data next cycle. Requests during CLEAR see ready=0 until clr_busy falls.
- Reset mid-clear: rst_n=0 at clear cycle 100 -> clr_busy=0, no clr_done pulse. Addr 0x00 reads 0, addr 0xFF retains its preload.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizing for the two-requester RAM controller.
package ram_ctrl_pkg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } ram_ctrl_state_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. gnt[0] is requester A, gnt[1] is requester B.
// The grant is combinational; the priority pointer moves only on acceptance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    input  logic       enable,
    output logic [1:0] gnt
);
    import ram_ctrl_pkg::*;

    gnt_t rr_last;

    // Pick a requester; under contention favour the one not served last.
    always_comb begin
        // NOTE: default first so every path assigns gnt and no latch is inferred.
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_last == GNT_B) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Remember the last served requester; after reset A wins first.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
        if (!rst_n) begin
            rr_last <= GNT_B;
        end else if (accept && (gnt != 2'b00)) begin
            rr_last <= gnt[1] ? GNT_B : GNT_A;
        end
    end

endmodule

// File: rtl/ram_arb_ctrl.sv
// Two-requester controller for a single-port synchronous RAM with a
// hardware zero-fill sequencer. One RAM access per cycle; read data is
// returned the cycle after acceptance straight from the RAM output register.
module ram_arb_ctrl #(
    parameter int WIDTH = ram_ctrl_pkg::WIDTH,
    parameter int DEPTH = ram_ctrl_pkg::DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_we,
    input  logic [DEPTH-1:0] a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_we,
    input  logic [DEPTH-1:0] b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             clr_done,
    output logic [DEPTH-1:0] ram_addr,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);
    import ram_ctrl_pkg::*;

    ram_ctrl_state_t  state;
    logic [DEPTH-1:0] clr_cnt;
    logic [1:0]       gnt;
    logic             arb_enable;
    logic             clr_last;

    // Arbitration is live only in IDLE and out of reset, so ready stays low
    // while rst_n is asserted and throughout a clear.
    assign arb_enable = rst_n && (state == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({b_valid, a_valid}),
        .accept (gnt != 2'b00),
        .enable (arb_enable),
        .gnt    (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];

    // The counter stops at all-ones and the terminal match ends the clear,
    // so it never needs to wrap to reach the final address.
    assign clr_last = (state == CLEAR) && (clr_cnt == {DEPTH{1'b1}});
    assign clr_busy = (state == CLEAR);
    assign clr_done = clr_last;

    // Read data passes straight through; it is only meaningful with rvalid.
    assign a_rdata = ram_dout;
    assign b_rdata = ram_dout;

    // Steer the RAM port from the clear sequencer or the granted request.
    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_din  = '0;
        if (state == CLEAR) begin
            ram_addr = clr_cnt;
            ram_we   = 1'b1;
        end else if (gnt[0]) begin
            ram_addr = a_addr;
            ram_we   = a_we;
            ram_din  = a_wdata;
        end else if (gnt[1]) begin
            ram_addr = b_addr;
            ram_we   = b_we;
            ram_din  = b_wdata;
        end
    end

    // Clear FSM and address counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    clr_cnt <= '0;
                    if (clr_start) state <= CLEAR;
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read responses: one-cycle pulse after a read is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= gnt[0] && !a_we;
            b_rvalid <= gnt[1] && !b_we;
        end
    end

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Self-checking bench for ram_arb_ctrl with a behavioural single-port RAM
// (registered read, output held during write cycles).
module tb_ram_arb_ctrl;

    localparam int W = 32;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_valid, a_we, b_valid, b_we, clr_start;
    logic [D-1:0] a_addr, b_addr;
    logic [W-1:0] a_wdata, b_wdata;
    logic         a_ready, b_ready, a_rvalid, b_rvalid;
    logic [W-1:0] a_rdata, b_rdata;
    logic         clr_busy, clr_done;
    logic [D-1:0] ram_addr;
    logic         ram_we;
    logic [W-1:0] ram_din, ram_dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_arb_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // Behavioural RAM: write on we, otherwise register the addressed word.
    logic [W-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        else        ram_dout      <= mem[ram_addr];
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        clr_start = 0;
    endtask

    // One A-only request cycle; A must be granted.
    task automatic a_req(input logic we, input logic [D-1:0] addr, input logic [W-1:0] data);
        next_cycle();
        drive_idle();
        a_valid = 1; a_we = we; a_addr = addr; a_wdata = data;
        @(negedge clk);
        check("a_req_ready", a_ready, 1'b1);
    endtask

    // A-only read followed by the response cycle.
    task automatic a_read_check(input string name, input logic [D-1:0] addr, input logic [W-1:0] exp);
        a_req(1'b0, addr, '0);
        next_cycle();
        drive_idle();
        @(negedge clk);
        check({name, "_rvalid"}, a_rvalid, 1'b1);
        check({name, "_rdata"}, a_rdata, exp);
    endtask

    typedef struct {
        logic         av, awe;
        logic [D-1:0] aaddr;
        logic [W-1:0] awd;
        logic         bv, bwe;
        logic [D-1:0] baddr;
        logic [W-1:0] bwd;
        logic         ea_rdy, eb_rdy, ea_rv, eb_rv;
        logic [W-1:0] ea_rd, eb_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic av, awe, input logic [D-1:0] aaddr, input logic [W-1:0] awd,
        input logic bv, bwe, input logic [D-1:0] baddr, input logic [W-1:0] bwd,
        input logic ea_rdy, eb_rdy, ea_rv, eb_rv,
        input logic [W-1:0] ea_rd, eb_rd);
        vec_t v;
        v.av = av; v.awe = awe; v.aaddr = aaddr; v.awd = awd;
        v.bv = bv; v.bwe = bwe; v.baddr = baddr; v.bwd = bwd;
        v.ea_rdy = ea_rdy; v.eb_rdy = eb_rdy; v.ea_rv = ea_rv; v.eb_rv = eb_rv;
        v.ea_rd = ea_rd; v.eb_rd = eb_rd;
        return v;
    endfunction

    vec_t vecs [12];
    logic done_seen;

    initial begin
        // A write/read, preload, contention alternating A,B,A,B, lone B.
        vecs[0]  = mk(1, 1, 8'h05, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
        vecs[1]  = mk(1, 0, 8'h05, 32'h0,        0, 0, 8'h00, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
        vecs[2]  = mk(0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0);
        vecs[3]  = mk(1, 1, 8'h10, 32'h11111111, 0, 0, 8'h00, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
        vecs[4]  = mk(0, 0, 8'h00, 32'h0, 1, 1, 8'h20, 32'h22222222, 0, 1, 0, 0, 32'h0, 32'h0);
        vecs[5]  = mk(1, 0, 8'h10, 32'h0, 1, 0, 8'h20, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
        vecs[6]  = mk(1, 0, 8'h10, 32'h0, 1, 0, 8'h20, 32'h0, 0, 1, 1, 0, 32'h11111111, 32'h0);
        vecs[7]  = mk(1, 0, 8'h10, 32'h0, 1, 0, 8'h20, 32'h0, 1, 0, 0, 1, 32'h0, 32'h22222222);
        vecs[8]  = mk(1, 0, 8'h10, 32'h0, 1, 0, 8'h20, 32'h0, 0, 1, 1, 0, 32'h11111111, 32'h0);
        vecs[9]  = mk(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 1, 32'h0, 32'h22222222);
        vecs[10] = mk(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0);
        vecs[11] = mk(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 1, 32'h0, 32'h22222222);

        // Reset held three cycles with A requesting.
        drive_idle();
        rst_n = 0;
        a_valid = 1; a_addr = 8'h03;
        repeat (3) begin
            @(negedge clk);
            check("rst_a_ready", a_ready, 1'b0);
        end
        check("rst_flags", {a_rvalid, b_rvalid, clr_busy, clr_done, ram_we, b_ready}, 6'b0);
        check("rst_ram_addr", ram_addr, 8'h00);
        check("rst_ram_din", ram_din, 32'h0);

        // First cycle after release: A is granted.
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        check("rel_a_ready", a_ready, 1'b1);
        check("rel_ram_addr", ram_addr, 8'h03);
        next_cycle();
        drive_idle();
        @(negedge clk);
        check("rel_a_rvalid", a_rvalid, 1'b1);

        // Table-driven single-requester and contention vectors.
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            a_valid = vecs[i].av; a_we = vecs[i].awe; a_addr = vecs[i].aaddr; a_wdata = vecs[i].awd;
            b_valid = vecs[i].bv; b_we = vecs[i].bwe; b_addr = vecs[i].baddr; b_wdata = vecs[i].bwd;
            @(negedge clk);
            check($sformatf("v%0d_a_ready", i), a_ready, vecs[i].ea_rdy);
            check($sformatf("v%0d_b_ready", i), b_ready, vecs[i].eb_rdy);
            check($sformatf("v%0d_a_rvalid", i), a_rvalid, vecs[i].ea_rv);
            check($sformatf("v%0d_b_rvalid", i), b_rvalid, vecs[i].eb_rv);
            if (vecs[i].ea_rv) check($sformatf("v%0d_a_rdata", i), a_rdata, vecs[i].ea_rd);
            if (vecs[i].eb_rv) check($sformatf("v%0d_b_rdata", i), b_rdata, vecs[i].eb_rd);
        end

        // Full clear with a read accepted alongside clr_start.
        a_req(1'b1, 8'h00, 32'hFFFFFFFF);
        a_req(1'b1, 8'hFF, 32'hFFFFFFFF);
        a_req(1'b1, 8'h07, 32'h77777777);
        next_cycle();
        drive_idle();
        a_valid = 1; a_addr = 8'h07; clr_start = 1;
        @(negedge clk);
        check("ovl_a_ready", a_ready, 1'b1);
        check("ovl_busy", clr_busy, 1'b0);
        for (int i = 0; i < 256; i++) begin
            next_cycle();
            clr_start = (i == 50);
            a_valid = 1; a_we = 0; a_addr = 8'h00;
            b_valid = 1; b_we = 0; b_addr = 8'hFF;
            @(negedge clk);
            if (i == 0) begin
                check("ovl_rvalid", a_rvalid, 1'b1);
                check("ovl_rdata", a_rdata, 32'h77777777);
            end
            check($sformatf("clr%0d_flags", i),
                  {clr_busy, clr_done, ram_we, a_ready, b_ready},
                  {1'b1, (i == 255), 1'b1, 1'b0, 1'b0});
            check($sformatf("clr%0d_addr", i), ram_addr, i[7:0]);
            check($sformatf("clr%0d_din", i), ram_din, 32'h0);
        end
        // Busy falls; B wins since A was served last.
        next_cycle();
        @(negedge clk);
        check("post_clr_flags", {clr_busy, clr_done}, 2'b00);
        check("post_clr_b_ready", b_ready, 1'b1);
        check("post_clr_a_ready", a_ready, 1'b0);
        next_cycle();
        @(negedge clk);
        check("post_clr_b_rvalid", b_rvalid, 1'b1);
        check("post_clr_b_rdata", b_rdata, 32'h0);
        check("post_clr_a_ready2", a_ready, 1'b1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        check("post_clr_a_rvalid", a_rvalid, 1'b1);
        check("post_clr_a_rdata", a_rdata, 32'h0);

        // Reset in the middle of a clear.
        a_req(1'b1, 8'h00, 32'hFFFFFFFF);
        a_req(1'b1, 8'hFF, 32'hFFFFFFFF);
        next_cycle();
        drive_idle();
        clr_start = 1;
        @(negedge clk);
        done_seen = 0;
        for (int i = 1; i <= 100; i++) begin
            next_cycle();
            clr_start = 0;
            if (i == 100) rst_n = 0;
            @(negedge clk);
            done_seen = done_seen | clr_done;
            if (i == 1 || i == 100) check($sformatf("mid%0d_busy", i), clr_busy, 1'b1);
        end
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        check("mid_abort_flags", {clr_busy, clr_done, done_seen}, 3'b000);
        a_read_check("mid_addr00", 8'h00, 32'h0);
        a_read_check("mid_addrFF", 8'hFF, 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
